mul_seq_unit: RTL

//  Multi-cycle responder for MUL-class ops (MUL, MULT, MULTU, MADD, MADDU, MSUB,

---
 rtl/mul_seq_unit_pkg.sv | 52 +++++
 rtl/mul_seq_unit_shift_add.sv | 79 +++++++
 rtl/mul_seq_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mul_seq_unit_pkg.sv
// mul_seq_unit_pkg
//   Shared constants for the multi-cycle MUL-class unit: function codes seen on
//   Func, the sequencer state encoding and the default datapath width, plus
//   small decode helpers used by the top level.
package mul_seq_unit_pkg;

  localparam int WIDTH_DEF = 32;

  // Function codes (ADD is listed so other blocks share one encoding table).
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_MUL   = 6'h1A;
  localparam logic [5:0] F_MADD  = 6'h1C;
  localparam logic [5:0] F_MADDU = 6'h1D;
  localparam logic [5:0] F_MSUB  = 6'h1E;
  localparam logic [5:0] F_MSUBU = 6'h1F;
  localparam logic [5:0] F_CLZ   = 6'h3C;
  localparam logic [5:0] F_CLO   = 6'h3D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // True for every code this unit responds to.
  function automatic logic is_supported(input logic [5:0] f);
    case (f)
      F_MUL, F_MULT, F_MULTU, F_MADD, F_MADDU,
      F_MSUB, F_MSUBU, F_CLO, F_CLZ: is_supported = 1'b1;
      default:                       is_supported = 1'b0;
    endcase
  endfunction

  // True for the multiplies that treat operands as two's complement.
  function automatic logic is_signed_op(input logic [5:0] f);
    case (f)
      F_MUL, F_MULT, F_MADD, F_MSUB: is_signed_op = 1'b1;
      default:                       is_signed_op = 1'b0;
    endcase
  endfunction

  // True for the leading-ones / leading-zeros count ops.
  function automatic logic is_count_op(input logic [5:0] f);
    case (f)
      F_CLO, F_CLZ: is_count_op = 1'b1;
      default:      is_count_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mul_seq_unit_shift_add.sv
// mul_shift_add
//   Radix-2 shift-add iteration datapath. start_i loads operand magnitudes and
//   clears the accumulator and iteration count; each step_i cycle adds the
//   shifted multiplicand when the current multiplier bit is set.
//   Ports: clk/rst_n, start_i, step_i, signed_i, a_i, b_i (WIDTH),
//          count_o (CNTW, steps taken), last_o (current step is the final one),
//          product_o (2*WIDTH, sign-corrected result including this step's add).
module mul_shift_add #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               step_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [CNTW-1:0]    count_o,
  output logic               last_o,
  output logic [2*WIDTH-1:0] product_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_next;
  logic [WIDTH-1:0]   mplier_q, mplier_d, mag_a, mag_b;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               neg_q, neg_d, a_neg, b_neg;

  // Next-state of the iteration registers and the sign-corrected product.
  always_comb begin
    a_neg    = signed_i & a_i[WIDTH-1];
    b_neg    = signed_i & b_i[WIDTH-1];
    // Magnitude stays correct for MIN_INT because it is read as unsigned.
    mag_a    = a_neg ? ({WIDTH{1'b0}} - a_i) : a_i;
    mag_b    = b_neg ? ({WIDTH{1'b0}} - b_i) : b_i;
    acc_next = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    if (start_i) begin
      acc_d    = {(2*WIDTH){1'b0}};
      mcand_d  = {{WIDTH{1'b0}}, mag_a};
      mplier_d = mag_b;
      cnt_d    = {CNTW{1'b0}};
      neg_d    = a_neg ^ b_neg;
    end else if (step_i) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      acc_d    = acc_q;
    end
    product_o = neg_q ? ({(2*WIDTH){1'b0}} - acc_next) : acc_next;
  end

  assign count_o = cnt_q;
  assign last_o  = (cnt_q == CNTW'(WIDTH - 1));

  // Iteration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CNTW{1'b0}};
      neg_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: rtl/mul_seq_unit.sv
// mul_seq_unit
//   Multi-cycle responder for MUL-class ops from EX. Owns HI/LO, runs the
//   IDLE -> BUSY -> DONE sequencer and the CLO/CLZ scan.
//   Ports: Clock, nReset (async active-low), MULOp, Func[5:0], In1, In2 (WIDTH),
//          Stall (comb on issue, then from state), Done (one-cycle pulse),
//          Out (GPR result), HI, LO.
module mul_seq_unit
  import mul_seq_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = 6
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             MULOp,
  input  logic [5:0]       Func,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_e             state_q, state_d;
  logic [5:0]         func_q, func_d;
  logic [WIDTH-1:0]   scan_q, scan_d, hi_q, hi_d, lo_q, lo_d, out_q, out_d;
  logic [2*WIDTH-1:0] product, hl;
  logic [CNTW-1:0]    count;
  logic               issue, last, target;

  mul_shift_add #(.WIDTH(WIDTH), .CNTW(CNTW)) u_dp (
    .clk       (Clock),
    .rst_n     (nReset),
    .start_i   (issue),
    .step_i    (state_q == ST_BUSY),
    .signed_i  (is_signed_op(Func)),
    .a_i       (In1),
    .b_i       (In2),
    .count_o   (count),
    .last_o    (last),
    .product_o (product)
  );

  // Sequencer next state, scan and result register updates.
  always_comb begin
    // Only IDLE can issue, so an op still held during DONE is not re-taken.
    issue   = (state_q == ST_IDLE) && MULOp && is_supported(Func);
    target  = (func_q == F_CLO);
    hl      = {hi_q, lo_q};
    state_d = state_q;
    func_d  = func_q;
    scan_d  = scan_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d = ST_BUSY;
          func_d  = Func;
          scan_d  = In1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (is_count_op(func_q)) begin
          // scan_q[MSB] is bit WIDTH-1-count of the latched operand.
          scan_d = scan_q << 1;
          if (scan_q[WIDTH-1] != target) begin
            out_d   = WIDTH'(count);
            state_d = ST_DONE;
          end else if (last) begin
            out_d   = WIDTH'(WIDTH);
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end else if (last) begin
          state_d = ST_DONE;
          case (func_q)
            F_MUL:           out_d        = product[WIDTH-1:0];
            F_MULT, F_MULTU: {hi_d, lo_d} = product;
            F_MADD, F_MADDU: {hi_d, lo_d} = hl + product;
            F_MSUB, F_MSUBU: {hi_d, lo_d} = hl - product;
            default:         out_d        = out_q;
          endcase
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state and architectural result registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      func_q  <= 6'h00;
      scan_q  <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      out_q   <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      scan_q  <= scan_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      out_q   <= out_d;
    end
  end

  // Stall is gated by reset so an op presented during reset never holds the pipe.
  assign Stall = nReset && (issue || (state_q == ST_BUSY));
  assign Done  = (state_q == ST_DONE);
  assign Out   = out_q;
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule
